exe_wb_arbiter: RTL and testbench

EXE_WB_ARBITER -- requirements
Module: exe_wb_arbiter

---
 rtl/exe_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_exe_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs merged onto a single register-file write port.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise the highest non-empty index wins.
module exe_wb_arbiter #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_W    = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_UNITS-1:0]          wr_allow,
  input  logic [N_UNITS*RD_W-1:0]     in_Rd,
  input  logic [N_UNITS*DATA_W-1:0]   in_result,
  input  logic                        wb_stall,
  output logic [N_UNITS-1:0]          busy,
  output logic [N_UNITS-1:0]          ovf_err,
  output logic                        final_valid,
  output logic [RD_W-1:0]             final_Rd,
  output logic [DATA_W-1:0]           final_result
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(N_UNITS);

  logic [RD_W-1:0]   rd_mem_q  [N_UNITS][DEPTH];
  logic [DATA_W-1:0] res_mem_q [N_UNITS][DEPTH];
  logic [PtrW-1:0]   wptr_q    [N_UNITS];
  logic [PtrW-1:0]   rptr_q    [N_UNITS];
  logic [CntW-1:0]   cnt_q     [N_UNITS];

  logic [N_UNITS-1:0] ovf_q;
  logic [N_UNITS-1:0] nonempty;
  logic [N_UNITS-1:0] full;
  logic [N_UNITS-1:0] push;
  logic [N_UNITS-1:0] pop;

  logic              valid_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] res_q;

  logic              free;
  logic              gnt_valid;
  logic [IdxW-1:0]   gnt_idx;

  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      full[i]     = (cnt_q[i] == CntW'(DEPTH));
    end
  end

  assign busy         = full;
  assign ovf_err      = ovf_q;
  assign final_valid  = valid_q;
  assign final_Rd     = rd_q;
  assign final_result = res_q;

  assign free = !valid_q || !wb_stall;

`ifdef WB_RR_ARB_EN
  logic [IdxW-1:0] last_q;

  // Search starts just after the last granted channel and wraps.
  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      cand     = (32'(last_q) + 1 + k) % N_UNITS;
      cand_idx = IdxW'(cand);
      if (!gnt_valid && nonempty[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IdxW'(N_UNITS - 1);
    end else if (free && gnt_valid) begin
      last_q <= gnt_idx;
    end
  end
`else
  // Later iterations overwrite earlier ones, so the highest non-empty index wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (nonempty[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(i);
      end
    end
  end
`endif

  always_comb begin
    pop  = '0;
    push = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      pop[i]  = free && gnt_valid && (gnt_idx == IdxW'(i));
      push[i] = wr_allow[i] && (!full[i] || pop[i]);
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (push[i]) begin
        rd_mem_q[i][wptr_q[i]]  <= in_Rd[i*RD_W +: RD_W];
        res_mem_q[i][wptr_q[i]] <= in_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_UNITS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q   <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (pop[i] && !push[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
        if (wr_allow[i] && !push[i]) ovf_q[i] <= 1'b1;
      end
      if (free) begin
        valid_q <= gnt_valid;
        rd_q    <= gnt_valid ? rd_mem_q[gnt_idx][rptr_q[gnt_idx]] : '0;
        res_q   <= gnt_valid ? res_mem_q[gnt_idx][rptr_q[gnt_idx]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Directed bench for exe_wb_arbiter (N_UNITS=4, DEPTH=2); expectations follow WB_RR_ARB_EN.
module tb_exe_wb_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   wr_allow;
  logic [15:0]  in_Rd;
  logic [127:0] in_result;
  logic         wb_stall;
  logic [3:0]   busy;
  logic [3:0]   ovf_err;
  logic         final_valid;
  logic [3:0]   final_Rd;
  logic [31:0]  final_result;

  int n_vec;
  int n_err;

  exe_wb_arbiter #(
    .N_UNITS(4),
    .DATA_W (32),
    .RD_W   (4),
    .DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_allow    (wr_allow),
    .in_Rd       (in_Rd),
    .in_result   (in_result),
    .wb_stall    (wb_stall),
    .busy        (busy),
    .ovf_err     (ovf_err),
    .final_valid (final_valid),
    .final_Rd    (final_Rd),
    .final_result(final_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   wr;
    logic [15:0]  rd;
    logic [127:0] res;
    logic         stall;
    logic         ev;
    logic [3:0]   erd;
    logic [31:0]  eres;
    logic [3:0]   ebusy;
    logic [3:0]   eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] wr, input logic [15:0] rd, input logic [127:0] res,
                     input logic stall, input logic ev, input logic [3:0] erd,
                     input logic [31:0] eres, input logic [3:0] ebusy, input logic [3:0] eovf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.res = res; v.stall = stall;
    v.ev = ev; v.erd = erd; v.eres = eres; v.ebusy = ebusy; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic ev, input logic [3:0] erd,
                       input logic [31:0] eres, input logic [3:0] eb, input logic [3:0] eo);
    n_vec++;
    if ({final_valid, final_Rd, final_result, busy, ovf_err} !== {ev, erd, eres, eb, eo}) begin
      n_err++;
      $display("FAIL %s: got v=%0b rd=%0d res=%h busy=%b ovf=%b, want v=%0b rd=%0d res=%h busy=%b ovf=%b",
               nm, final_valid, final_Rd, final_result, busy, ovf_err, ev, erd, eres, eb, eo);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic idle_inputs();
    wr_allow = '0; in_Rd = '0; in_result = '0; wb_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [127:0] ResAll = {32'h44, 32'h33, 32'h22, 32'h11};

  initial begin
    int grants;
    logic [3:0] want_rd;
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Single push, simultaneous push, stall hold with channel-1 overflow
    add(4'b0000, 16'h0000, '0, 0,  0, 0, 0, 4'b0000, 4'b0000);
    add(4'b1000, 16'h3000, {32'hAA, 96'h0}, 0,  0, 0, 0, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 3, 32'hAA, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  0, 0, 0, 4'b0000, 4'b0000);
    add(4'b1111, 16'h4321, ResAll, 0,  0, 0, 0, 4'b0000, 4'b0000);
`ifdef WB_RR_ARB_EN
    add(4'b0000, 16'h0000, '0, 0,  1, 1, 32'h11, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 2, 32'h22, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 3, 32'h33, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 4, 32'h44, 4'b0000, 4'b0000);
`else
    add(4'b0000, 16'h0000, '0, 0,  1, 4, 32'h44, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 3, 32'h33, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 2, 32'h22, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 0,  1, 1, 32'h11, 4'b0000, 4'b0000);
`endif
    add(4'b0000, 16'h0000, '0, 0,  0, 0, 0, 4'b0000, 4'b0000);
    add(4'b0100, 16'h0700, {32'h0, 32'h1234, 64'h0}, 0,  0, 0, 0, 4'b0000, 4'b0000);
    add(4'b0000, 16'h0000, '0, 1,  1, 7, 32'h1234, 4'b0000, 4'b0000);
    add(4'b0010, 16'h0050, {64'h0, 32'h501, 32'h0}, 1,  1, 7, 32'h1234, 4'b0000, 4'b0000);
    add(4'b0010, 16'h0060, {64'h0, 32'h602, 32'h0}, 1,  1, 7, 32'h1234, 4'b0010, 4'b0000);
    add(4'b0010, 16'h0080, {64'h0, 32'h803, 32'h0}, 1,  1, 7, 32'h1234, 4'b0010, 4'b0010);
    add(4'b0000, 16'h0000, '0, 1,  1, 7, 32'h1234, 4'b0010, 4'b0010);
    add(4'b0000, 16'h0000, '0, 1,  1, 7, 32'h1234, 4'b0010, 4'b0010);
    add(4'b0000, 16'h0000, '0, 0,  1, 5, 32'h501, 4'b0000, 4'b0010);
    add(4'b0000, 16'h0000, '0, 0,  1, 6, 32'h602, 4'b0000, 4'b0010);
    add(4'b0000, 16'h0000, '0, 0,  0, 0, 0, 4'b0000, 4'b0010);
    add(4'b0000, 16'h0000, '0, 0,  0, 0, 0, 4'b0000, 4'b0010);

    #12 check("reset_state", 0, 0, 0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      wr_allow  = vecs[i].wr;
      in_Rd     = vecs[i].rd;
      in_result = vecs[i].res;
      wb_stall  = vecs[i].stall;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erd, vecs[i].eres,
               vecs[i].ebusy, vecs[i].eovf);
    end

    // Channels 0 and 3 pushed whenever they are not busy
    do_reset();
    grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
      wr_allow  = {!busy[3], 2'b00, !busy[0]};
      in_Rd     = {4'd13, 8'h00, 4'd10};
      in_result = {32'hD, 64'h0, 32'hA};
      @(posedge clk);
      #1;
      if (final_valid) begin
`ifdef WB_RR_ARB_EN
        want_rd = (grants % 2 == 0) ? 4'd10 : 4'd13;
`else
        want_rd = 4'd13;
`endif
        check_val($sformatf("arb_grant%0d", grants), 32'(final_Rd), 32'(want_rd));
        grants++;
      end
    end
    if (grants < 8) begin
      n_vec++;
      n_err++;
      $display("FAIL arb_timeout: got %0d grants, want 8", grants);
    end
    check_val("arb_no_ovf", 32'(ovf_err), 32'h0);
`ifndef WB_RR_ARB_EN
    check_val("fixed_ch0_starved_busy", 32'(busy[0]), 32'h1);
`endif

    // Reset while channel 2 holds two entries behind a stalled output
    do_reset();
    wr_allow = 4'b0010; in_Rd = 16'h0090; in_result = {64'h0, 32'h99, 32'h0};
    @(posedge clk);
    #1 wr_allow = 4'b0100; in_Rd = 16'h0B00; in_result = {32'h0, 32'hBB, 64'h0};
    wb_stall = 1'b1;
    @(posedge clk);
    #1 wr_allow = 4'b0100; in_Rd = 16'h0C00; in_result = {32'h0, 32'hCC, 64'h0};
    @(posedge clk);
    #1 check("pre_reset", 1, 9, 32'h99, 4'b0100, 4'b0000);
    idle_inputs();
    wb_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 0, 0, 0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wb_stall = 1'b0;
    wr_allow = 4'b0001; in_Rd = 16'h000E; in_result = {96'h0, 32'hEE};
    @(posedge clk);
    #1 check("post_reset_push", 0, 0, 0, 4'b0000, 4'b0000);
    idle_inputs();
    @(posedge clk);
    #1 check("post_reset_wb", 1, 14, 32'hEE, 4'b0000, 4'b0000);
    @(posedge clk);
    #1 check("no_stale_1", 0, 0, 0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1 check("no_stale_2", 0, 0, 0, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
